// File: rtl/quat_frame_tx.sv
// quat_frame_tx
// Byte-stream transmitter for the orientation filter's output quaternion.
// A load strobe captures q_w/q_i/q_j/q_k and the block emits a 12-byte frame:
//   SYNC0, SYNC1, SEQ, w_hi, w_lo, i_hi, i_lo, j_hi, j_lo, k_hi, k_lo, CHK
// where CHK is the XOR of bytes 2..10.
// A single pending slot absorbs one load while a frame is in flight.
// A second such load overwrites the slot and raises a one-cycle drop pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      capture strobe for q_*
//   q_w..q_k  16-bit signed quaternion components, passed through unmodified
//   tx_data   registered frame byte
//   tx_valid  tx_data is valid (high for the whole frame)
//   tx_ready  downstream accepts the byte when tx_valid & tx_ready
//   busy      frame in flight or pending slot occupied
//   drop      one-cycle pulse: pending sample was overwritten and lost
module quat_frame_tx #(
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] q_w,
  input  logic [15:0] q_i,
  input  logic [15:0] q_j,
  input  logic [15:0] q_k,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        drop
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;
  logic        drop_q, drop_d;
  logic [7:0]  seq_cnt_q, seq_cnt_d;
  logic [7:0]  frame_seq_q, frame_seq_d;

  logic [15:0] act_w_q, act_i_q, act_j_q, act_k_q;
  logic [15:0] act_w_d, act_i_d, act_j_d, act_k_d;
  logic [15:0] pend_w_q, pend_i_q, pend_j_q, pend_k_q;
  logic [15:0] pend_w_d, pend_i_d, pend_j_d, pend_k_d;
  logic        pend_full_q, pend_full_d;

  logic [3:0]  index_inc;
  logic [7:0]  next_byte;
  logic [7:0]  chk;
  logic        accept;
  logic        last_accept;
  logic        capture_new;
  logic        take_pend;
  logic        start_frame;

  assign tx_data  = data_q;
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND) | pend_full_q;
  assign drop     = drop_q;

  assign accept      = (state_q == SEND) & tx_ready;
  assign last_accept = accept & (index_q == 4'd11);

  // Checksum covers the sequence number and all eight payload bytes of the
  // active frame; the active registers are frozen for the frame's lifetime.
  assign chk = frame_seq_q
             ^ act_w_q[15:8] ^ act_w_q[7:0]
             ^ act_i_q[15:8] ^ act_i_q[7:0]
             ^ act_j_q[15:8] ^ act_j_q[7:0]
             ^ act_k_q[15:8] ^ act_k_q[7:0];

  // Because tx_data is registered, the byte loaded on an accept is the one
  // for the following index. Byte 0 of a new frame is handled separately.
  assign index_inc = index_q + 4'd1;

  always_comb begin
    next_byte = 8'h00;
    case (index_inc)
      4'd1:    next_byte = SYNC1;
      4'd2:    next_byte = frame_seq_q;
      4'd3:    next_byte = act_w_q[15:8];
      4'd4:    next_byte = act_w_q[7:0];
      4'd5:    next_byte = act_i_q[15:8];
      4'd6:    next_byte = act_i_q[7:0];
      4'd7:    next_byte = act_j_q[15:8];
      4'd8:    next_byte = act_j_q[7:0];
      4'd9:    next_byte = act_k_q[15:8];
      4'd10:   next_byte = act_k_q[7:0];
      4'd11:   next_byte = chk;
      default: next_byte = SYNC0;
    endcase
  end

  // Next-state logic. On the last-byte accept, a full pending slot takes
  // priority over a simultaneous load. That load then refills the freed
  // slot without a drop.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    data_d      = data_q;
    drop_d      = 1'b0;
    seq_cnt_d   = seq_cnt_q;
    frame_seq_d = frame_seq_q;
    act_w_d     = act_w_q;
    act_i_d     = act_i_q;
    act_j_d     = act_j_q;
    act_k_d     = act_k_q;
    pend_w_d    = pend_w_q;
    pend_i_d    = pend_i_q;
    pend_j_d    = pend_j_q;
    pend_k_d    = pend_k_q;
    pend_full_d = pend_full_q;
    capture_new = 1'b0;
    take_pend   = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          capture_new = 1'b1;
          start_frame = 1'b1;
        end
      end
      SEND: begin
        if (accept) begin
          if (index_q == 4'd11) begin
            if (pend_full_q) begin
              take_pend   = 1'b1;
              start_frame = 1'b1;
            end else if (load) begin
              capture_new = 1'b1;
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            index_d = index_inc;
            data_d  = next_byte;
          end
        end

        if (load && !last_accept) begin
          pend_w_d    = q_w;
          pend_i_d    = q_i;
          pend_j_d    = q_j;
          pend_k_d    = q_k;
          pend_full_d = 1'b1;
          drop_d      = pend_full_q;
        end

        if (last_accept && pend_full_q) begin
          pend_full_d = load;
          if (load) begin
            pend_w_d = q_w;
            pend_i_d = q_i;
            pend_j_d = q_j;
            pend_k_d = q_k;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture_new) begin
      act_w_d = q_w;
      act_i_d = q_i;
      act_j_d = q_j;
      act_k_d = q_k;
    end

    if (take_pend) begin
      act_w_d = pend_w_q;
      act_i_d = pend_i_q;
      act_j_d = pend_j_q;
      act_k_d = pend_k_q;
    end

    // A frame takes its sequence number as it enters byte 0.
    if (start_frame) begin
      state_d     = SEND;
      index_d     = 4'd0;
      data_d      = SYNC0;
      frame_seq_d = seq_cnt_q;
      seq_cnt_d   = seq_cnt_q + 8'd1;
    end
  end

  // State register. Reset abandons any partial frame and empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      index_q     <= 4'd0;
      data_q      <= 8'h00;
      drop_q      <= 1'b0;
      seq_cnt_q   <= 8'h00;
      frame_seq_q <= 8'h00;
      act_w_q     <= 16'h0000;
      act_i_q     <= 16'h0000;
      act_j_q     <= 16'h0000;
      act_k_q     <= 16'h0000;
      pend_w_q    <= 16'h0000;
      pend_i_q    <= 16'h0000;
      pend_j_q    <= 16'h0000;
      pend_k_q    <= 16'h0000;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
      seq_cnt_q   <= seq_cnt_d;
      frame_seq_q <= frame_seq_d;
      act_w_q     <= act_w_d;
      act_i_q     <= act_i_d;
      act_j_q     <= act_j_d;
      act_k_q     <= act_k_d;
      pend_w_q    <= pend_w_d;
      pend_i_q    <= pend_i_d;
      pend_j_q    <= pend_j_d;
      pend_k_q    <= pend_k_d;
      pend_full_q <= pend_full_d;
    end
  end

endmodule
